// File: rtl/hazard_unit_sb_pkg.sv
// Shared types and default sizing for the hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_RA_W     = $clog2(DEF_NUM_REGS);

endpackage

// File: rtl/hazard_unit_sb_fwd_sel.sv
// Forward select for a single EX source operand; MEM result beats WB result.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int RA_W = DEF_RA_W
) (
    input  logic [RA_W-1:0] src_i,
    input  logic            regwrite_mem_i,
    input  logic [RA_W-1:0] rdn_mem_i,
    input  logic            regwrite_wb_i,
    input  logic [RA_W-1:0] rdn_wb_i,
    output fwd_sel_t        fwd_o
);

    always_comb begin
        fwd_o = FWD_NONE;
        // r0 is hardwired zero, never forwarded
        if (src_i != '0) begin
            if (regwrite_mem_i && (rdn_mem_i == src_i)) begin
                fwd_o = FWD_MEM;
            end else if (regwrite_wb_i && (rdn_wb_i == src_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// Forwarding, stall/flush control and long-latency scoreboard.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int MAX_OUT  = 4,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RegWrite_MEM,
    input  logic                    RegWrite_WB,
    input  logic [RA_W-1:0]         rdn_MEM,
    input  logic [RA_W-1:0]         rdn_WB,
    input  logic [NUM_SRC*RA_W-1:0] src_EX,
    output logic [NUM_SRC*2-1:0]    ForwardSrc_EX,
    input  logic                    MemToReg_EX,
    input  logic                    LongIssue_EX,
    input  logic [RA_W-1:0]         rdn_EX,
    input  logic [NUM_SRC*RA_W-1:0] src_ID,
    input  logic [RA_W-1:0]         rdn_ID,
    input  logic                    RegWrite_ID,
    input  logic                    LongOp_ID,
    input  logic                    LongDone_valid,
    input  logic [RA_W-1:0]         LongDone_rd,
    input  logic                    Redirect_EX,
    output logic                    Stall_IF,
    output logic                    Stall_ID,
    output logic                    Flush_ID,
    output logic                    Flush_EX,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt,
`endif
    output logic [NUM_REGS-1:0]     busy
);

    localparam int             CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MAX_OUT - 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                issue_ok, done_ok;
    logic                ex_hit, raw_hit;
    logic                load_use, issue_haz, waw_haz, struct_haz, stall;
    fwd_sel_t            fwd_sel [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        hazard_fwd_sel #(.RA_W(RA_W)) u_fwd (
            .src_i          (src_EX[g*RA_W +: RA_W]),
            .regwrite_mem_i (RegWrite_MEM),
            .rdn_mem_i      (rdn_MEM),
            .regwrite_wb_i  (RegWrite_WB),
            .rdn_wb_i       (rdn_WB),
            .fwd_o          (fwd_sel[g])
        );
        assign ForwardSrc_EX[g*2 +: 2] = fwd_sel[g];
    end

    // Over-limit issues and under-flow completions leave the count alone.
    assign issue_ok = LongIssue_EX && (cnt_q != CNT_MAX);
    assign done_ok  = LongDone_valid && (cnt_q != '0);

    always_comb begin
        ex_hit  = 1'b0;
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ID[i*RA_W +: RA_W] != '0) begin
                if (rdn_EX == src_ID[i*RA_W +: RA_W]) ex_hit = 1'b1;
                if (busy_q[src_ID[i*RA_W +: RA_W]]) raw_hit = 1'b1;
            end
        end
    end

    assign load_use   = MemToReg_EX && (rdn_EX != '0) && ex_hit;
    assign issue_haz  = LongIssue_EX && (rdn_EX != '0) && ex_hit;
    assign waw_haz    = RegWrite_ID && (rdn_ID != '0) && busy_q[rdn_ID];
    assign struct_haz = LongOp_ID &&
                        ((cnt_q == CNT_MAX) ||
                         ((cnt_q == CNT_PRE) && issue_ok && !done_ok));
    assign stall      = load_use | issue_haz | raw_hit | waw_haz | struct_haz;

    always_comb begin
        Stall_IF = 1'b0;
        Stall_ID = 1'b0;
        Flush_ID = 1'b0;
        Flush_EX = 1'b0;
        if (Redirect_EX) begin
            Flush_ID = 1'b1;
            Flush_EX = 1'b1;
        end else if (stall) begin
            Stall_IF = 1'b1;
            Stall_ID = 1'b1;
            Flush_EX = 1'b1;
        end
    end

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (LongDone_valid) busy_d[LongDone_rd] = 1'b0;
        if (issue_ok)       busy_d[rdn_EX]      = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        unique case ({issue_ok, done_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !Redirect_EX && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (Redirect_EX && (flush_cnt_q != '1))           flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb (MAX_OUT=2) with a per-cycle reference model.
module tb_hazard_unit_sb;

    localparam int NS = 2;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int MO = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWrite_MEM, RegWrite_WB;
    logic [RW-1:0]   rdn_MEM, rdn_WB;
    logic [NS*RW-1:0] src_EX;
    logic [NS*2-1:0] ForwardSrc_EX;
    logic            MemToReg_EX, LongIssue_EX;
    logic [RW-1:0]   rdn_EX;
    logic [NS*RW-1:0] src_ID;
    logic [RW-1:0]   rdn_ID;
    logic            RegWrite_ID, LongOp_ID;
    logic            LongDone_valid;
    logic [RW-1:0]   LongDone_rd;
    logic            Redirect_EX;
    logic            Stall_IF, Stall_ID, Flush_ID, Flush_EX;
    logic [NR-1:0]   busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]     stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference state
    bit [NR-1:0] m_busy;
    int          m_cnt;

    always #5 clk = ~clk;

    hazard_unit_sb #(.NUM_SRC(NS), .NUM_REGS(NR), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .rdn_MEM(rdn_MEM), .rdn_WB(rdn_WB),
        .src_EX(src_EX), .ForwardSrc_EX(ForwardSrc_EX),
        .MemToReg_EX(MemToReg_EX), .LongIssue_EX(LongIssue_EX), .rdn_EX(rdn_EX),
        .src_ID(src_ID), .rdn_ID(rdn_ID), .RegWrite_ID(RegWrite_ID), .LongOp_ID(LongOp_ID),
        .LongDone_valid(LongDone_valid), .LongDone_rd(LongDone_rd),
        .Redirect_EX(Redirect_EX),
        .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state update: issues beyond the limit and completions at zero are dropped.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = '0;
            m_cnt  = 0;
        end else begin
            bit iss, dn;
            iss = LongIssue_EX && (m_cnt < MO);
            dn  = LongDone_valid && (m_cnt > 0);
            if (LongDone_valid) m_busy[LongDone_rd] = 1'b0;
            if (iss && rdn_EX != 0) m_busy[rdn_EX] = 1'b1;
            m_cnt = m_cnt + int'(iss) - int'(dn);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NS*2-1:0] e_fwd;
            bit ex_hit, raw, stall, iss, dn, strc;
            logic [3:0] e_ctl;
            e_fwd  = '0;
            ex_hit = 0;
            raw    = 0;
            for (int i = 0; i < NS; i++) begin
                int s, d;
                s = int'(src_EX[i*RW +: RW]);
                if (s != 0) begin
                    if (RegWrite_MEM && int'(rdn_MEM) == s)     e_fwd[i*2 +: 2] = 2'b10;
                    else if (RegWrite_WB && int'(rdn_WB) == s)  e_fwd[i*2 +: 2] = 2'b01;
                end
                d = int'(src_ID[i*RW +: RW]);
                if (d != 0) begin
                    if (int'(rdn_EX) == d) ex_hit = 1;
                    if (m_busy[d]) raw = 1;
                end
            end
            iss  = LongIssue_EX && (m_cnt < MO);
            dn   = LongDone_valid && (m_cnt > 0);
            strc = LongOp_ID && ((m_cnt == MO) || (m_cnt == MO - 1 && iss && !dn));
            stall = ((MemToReg_EX || LongIssue_EX) && rdn_EX != 0 && ex_hit) || raw ||
                    (RegWrite_ID && rdn_ID != 0 && m_busy[rdn_ID]) || strc;
            // {Stall_IF, Stall_ID, Flush_ID, Flush_EX}
            if (Redirect_EX) e_ctl = 4'b0011;
            else if (stall)  e_ctl = 4'b1101;
            else             e_ctl = 4'b0000;
            chk("model_fwd", 64'(ForwardSrc_EX), 64'(e_fwd));
            chk("model_ctl", 64'({Stall_IF, Stall_ID, Flush_ID, Flush_EX}), 64'(e_ctl));
            chk("model_busy", 64'(busy), 64'(m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        RegWrite_MEM = 0; RegWrite_WB = 0; rdn_MEM = 0; rdn_WB = 0; src_EX = '0;
        MemToReg_EX = 0; LongIssue_EX = 0; rdn_EX = 0; src_ID = '0; rdn_ID = 0;
        RegWrite_ID = 0; LongOp_ID = 0; LongDone_valid = 0; LongDone_rd = 0; Redirect_EX = 0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_ctl", 64'({Stall_IF, Stall_ID, Flush_ID, Flush_EX}), 64'h0);

        // forwarding priority
        src_EX = {5'd0, 5'd5};
        RegWrite_MEM = 1; rdn_MEM = 5; RegWrite_WB = 1; rdn_WB = 5;
        #1 chk("fwd_mem_prio", 64'(ForwardSrc_EX), 64'h2);
        tick();
        src_EX = {5'd5, 5'd0};
        #1 chk("fwd_src0", 64'(ForwardSrc_EX), 64'h8);
        tick();
        src_EX = {5'd6, 5'd5}; RegWrite_MEM = 1; rdn_MEM = 5; rdn_WB = 6;
        #1 chk("fwd_mixed", 64'(ForwardSrc_EX), 64'h6);
        tick();
        src_EX = {5'd0, 5'd0};
        #1 chk("fwd_zero", 64'(ForwardSrc_EX), 64'h0);
        RegWrite_MEM = 0; RegWrite_WB = 0; rdn_MEM = 0; rdn_WB = 0;
        tick();

        // load-use
        MemToReg_EX = 1; rdn_EX = 7; src_ID = {5'd7, 5'd0};
        #1 chk("loaduse_ctl", 64'({Stall_IF, Stall_ID, Flush_ID, Flush_EX}), 64'hD);
        tick();
        rdn_EX = 0; src_ID = '0;
        #1 chk("loaduse_r0", 64'(Stall_IF), 64'h0);
        tick();
        MemToReg_EX = 0;

        // long op scoreboard
        LongIssue_EX = 1; rdn_EX = 9;
        tick();
        LongIssue_EX = 0; rdn_EX = 0; src_ID = {5'd0, 5'd9};
        #1 chk("raw_busy9", 64'(busy[9]), 64'h1);
        chk("raw_stall", 64'(Stall_ID), 64'h1);
        tick();
        LongDone_valid = 1; LongDone_rd = 9;
        #1 chk("raw_done_cycle", 64'(Stall_ID), 64'h1);
        tick();
        LongDone_valid = 0;
        #1 chk("raw_cleared", 64'(busy[9]), 64'h0);
        chk("raw_stall_drop", 64'(Stall_ID), 64'h0);
        src_ID = '0;
        tick();

        // issue hazard against ID operand
        LongIssue_EX = 1; rdn_EX = 10; src_ID = {5'd10, 5'd0};
        #1 chk("issue_haz", 64'(Stall_IF), 64'h1);
        tick();
        LongIssue_EX = 0; rdn_EX = 0; src_ID = '0; LongDone_valid = 1; LongDone_rd = 10;
        tick();
        LongDone_valid = 0;

        // structural limit (MAX_OUT=2)
        LongIssue_EX = 1; rdn_EX = 3;
        tick();
        rdn_EX = 4; LongOp_ID = 1;
        #1 chk("struct_pre", 64'(Stall_IF), 64'h1);
        tick();
        LongIssue_EX = 0; rdn_EX = 0;
        #1 chk("struct_full", 64'(Stall_IF), 64'h1);
        tick();
        LongDone_valid = 1; LongDone_rd = 4;
        #1 chk("struct_done_cycle", 64'(Stall_IF), 64'h1);
        tick();
        LongDone_valid = 0;
        #1 chk("struct_release", 64'(Stall_IF), 64'h0);
        chk("struct_busy4", 64'(busy[4]), 64'h0);
        LongIssue_EX = 1; rdn_EX = 3; LongDone_valid = 1; LongDone_rd = 3;
        #1 chk("issue_done_nostall", 64'(Stall_IF), 64'h0);
        tick();
        LongIssue_EX = 0; rdn_EX = 0; LongDone_valid = 0;
        #1 chk("set_wins_busy3", 64'(busy[3]), 64'h1);
        chk("cnt_held_nostall", 64'(Stall_IF), 64'h0);
        LongIssue_EX = 1; rdn_EX = 5;
        #1 chk("cnt_held_is1", 64'(Stall_IF), 64'h1);
        LongIssue_EX = 0; rdn_EX = 0; LongOp_ID = 0;
        tick();

        // WAW and redirect priority
        RegWrite_ID = 1; rdn_ID = 3;
        #1 chk("waw_stall", 64'({Stall_IF, Stall_ID, Flush_ID, Flush_EX}), 64'hD);
        rdn_ID = 0;
        #1 chk("waw_r0", 64'(Stall_IF), 64'h0);
        tick();
        rdn_ID = 3; Redirect_EX = 1;
        #1 chk("redirect_prio", 64'({Stall_IF, Stall_ID, Flush_ID, Flush_EX}), 64'h3);
        tick();
        Redirect_EX = 0; RegWrite_ID = 0; rdn_ID = 0;

        // reset mid-operation
        LongDone_valid = 1; LongDone_rd = 3;
        tick();
        LongDone_valid = 0; LongIssue_EX = 1; rdn_EX = 12;
        tick();
        LongIssue_EX = 0; rdn_EX = 0;
        #1 chk("pre_rst_busy12", 64'(busy[12]), 64'h1);
        rst = 1;
        tick();
        rst = 0;
        #1 chk("rst_busy", 64'(busy), 64'h0);
        LongDone_valid = 1; LongDone_rd = 12;
        tick();
        LongDone_valid = 0;
        #1 chk("rst_late_done", 64'(busy), 64'h0);
        LongOp_ID = 1; LongIssue_EX = 1; rdn_EX = 1;
        #1 chk("rst_cnt_zero", 64'(Stall_IF), 64'h0);
        tick();
        LongOp_ID = 0; LongIssue_EX = 0; rdn_EX = 0;
        tick(); tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
